// File: rtl/vardelay.sv
// rtl/vardelay.sv - variable-length delay line with runtime tap select and optional output register
module vardelay #(
    parameter int W        = 1,
    parameter int NMAX     = 8,
    parameter bit CLR_DATA = 1'b1,
    parameter bit OUTREG   = 1'b0,
    localparam int DW      = $clog2(NMAX + 1)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          step,
    input  logic          flush,
    input  logic [DW-1:0] dly,
    input  logic          in_valid,
    input  logic [W-1:0]  in,
    output logic          out_valid,
    output logic [W-1:0]  out
);
    localparam logic [DW-1:0] DMAX = DW'(NMAX);

    logic [W-1:0]  sdata [1:NMAX];
    logic [NMAX:1] svalid;
    logic [DW-1:0] tap;
    logic [W-1:0]  sel_data;
    logic          sel_valid;

    // flush only drops valid bits so held data costs no extra muxing
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            svalid <= '0;
            if (CLR_DATA) begin
                for (int k = 1; k <= NMAX; k++) begin
                    sdata[k] <= '0;
                end
            end
        end else if (flush) begin
            svalid <= '0;
        end else if (step) begin
            sdata[1]  <= in;
            svalid[1] <= in_valid;
            for (int k = 2; k <= NMAX; k++) begin
                sdata[k]  <= sdata[k-1];
                svalid[k] <= svalid[k-1];
            end
        end
    end

    assign tap = (dly > DMAX) ? DMAX : dly;

    // tap 0 falls through to the live input
    always_comb begin
        sel_data  = in;
        sel_valid = in_valid;
        for (int k = 1; k <= NMAX; k++) begin
            if (tap == DW'(k)) begin
                sel_data  = sdata[k];
                sel_valid = svalid[k];
            end
        end
    end

    generate
        if (OUTREG) begin : g_outreg
            logic [W-1:0] q_data;
            logic         q_valid;

            always_ff @(posedge clk) begin
                if (!clr_n) begin
                    q_valid <= 1'b0;
                    if (CLR_DATA) begin
                        q_data <= '0;
                    end
                end else begin
                    q_data  <= sel_data;
                    q_valid <= sel_valid & ~flush;
                end
            end

            assign out       = q_data;
            assign out_valid = q_valid;
        end else begin : g_comb
            assign out       = sel_data;
            assign out_valid = sel_valid;
        end
    endgenerate

endmodule

// File: tb/tb_vardelay.sv
// tb/tb_vardelay.sv - table-driven and scoreboard bench for vardelay
module tb_vardelay;
    localparam int W    = 8;
    localparam int NMAX = 8;
    localparam int DW   = 4;

    logic          clk = 1'b0;
    logic          clr_n, step, flush, in_valid;
    logic [DW-1:0] dly;
    logic [W-1:0]  in;
    logic          ov0, ov1, ov2;
    logic [W-1:0]  o0, o1, o2;

    always #5 clk = ~clk;

    vardelay #(.W(W), .NMAX(NMAX), .CLR_DATA(1'b1), .OUTREG(1'b0)) u0 (
        .clk(clk), .clr_n(clr_n), .step(step), .flush(flush), .dly(dly),
        .in_valid(in_valid), .in(in), .out_valid(ov0), .out(o0));
    vardelay #(.W(W), .NMAX(NMAX), .CLR_DATA(1'b1), .OUTREG(1'b1)) u1 (
        .clk(clk), .clr_n(clr_n), .step(step), .flush(flush), .dly(dly),
        .in_valid(in_valid), .in(in), .out_valid(ov1), .out(o1));
    vardelay #(.W(W), .NMAX(NMAX), .CLR_DATA(1'b0), .OUTREG(1'b0)) u2 (
        .clk(clk), .clr_n(clr_n), .step(step), .flush(flush), .dly(dly),
        .in_valid(in_valid), .in(in), .out_valid(ov2), .out(o2));

    typedef struct {
        bit       c, f, s;
        bit [3:0] d;
        bit       iv;
        bit [7:0] din;
        bit       chk, ev;
        bit [7:0] eo;
        bit       c2;
        bit [7:0] e2o;
    } vec_t;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } smp_t;

    vec_t tbl[$];
    smp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic void row(input bit c, input bit f, input bit s, input bit [3:0] d,
                                input bit iv, input bit [7:0] din, input bit chk, input bit ev,
                                input bit [7:0] eo, input bit c2, input bit [7:0] e2o);
        vec_t v;
        v.c = c; v.f = f; v.s = s; v.d = d; v.iv = iv; v.din = din;
        v.chk = chk; v.ev = ev; v.eo = eo; v.c2 = c2; v.e2o = e2o;
        tbl.push_back(v);
    endfunction

    task automatic chk_d(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: out=%02h expected %02h", name, idx, act, exp);
    endtask

    task automatic chk_v(input string name, input int idx, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: out_valid=%0b expected %0b", name, idx, act, exp);
    endtask

    initial begin
        smp_t e0, p0;
        vec_t v, pv;

        // reset, then bypass with step low
        row(0,0,1,3,1,'h77, 0,0,'h00, 0,'h00);
        row(0,0,1,3,1,'h77, 1,0,'h00, 0,'h00);
        row(1,0,0,3,1,'h11, 1,0,'h00, 0,'h00);
        row(1,0,0,0,1,'h5A, 1,1,'h5A, 1,'h5A);
        row(1,0,0,0,0,'h3C, 1,0,'h3C, 1,'h3C);
        // latency with dly=3
        row(1,0,1,3,1,'h01, 1,0,'h00, 0,'h00);
        row(1,0,1,3,1,'h02, 1,0,'h00, 0,'h00);
        row(1,0,1,3,1,'h03, 1,0,'h00, 0,'h00);
        row(1,0,1,3,1,'h04, 1,1,'h01, 1,'h01);
        row(1,0,1,3,1,'h05, 1,1,'h02, 1,'h02);
        row(1,0,1,3,1,'h06, 1,1,'h03, 1,'h03);
        row(1,0,1,3,1,'h07, 1,1,'h04, 1,'h04);
        row(1,0,1,3,1,'h08, 1,1,'h05, 1,'h05);
        // boundaries on a full line, then dly 4->2
        row(1,0,0,8,1,'h09, 1,1,'h01, 1,'h01);
        row(1,0,0,9,1,'h09, 1,1,'h01, 1,'h01);
        row(1,0,0,15,1,'h09, 1,1,'h01, 1,'h01);
        row(1,0,0,1,1,'h09, 1,1,'h08, 1,'h08);
        row(1,0,0,0,1,'h99, 1,1,'h99, 1,'h99);
        row(1,0,0,4,1,'h99, 1,1,'h05, 1,'h05);
        row(1,0,0,2,1,'h99, 1,1,'h07, 1,'h07);
        // stall with dly=2, step 1,1,0,0,1
        row(1,0,1,2,1,'hA0, 1,1,'h07, 1,'h07);
        row(1,0,1,2,1,'hA1, 1,1,'h08, 1,'h08);
        row(1,0,0,2,1,'hA2, 1,1,'hA0, 1,'hA0);
        row(1,0,0,2,1,'hA3, 1,1,'hA0, 1,'hA0);
        row(1,0,1,2,1,'hA4, 1,1,'hA0, 1,'hA0);
        row(1,0,0,2,1,'hA5, 1,1,'hA1, 1,'hA1);
        row(1,0,0,1,1,'hA5, 1,1,'hA4, 1,'hA4);
        row(1,0,0,3,1,'hA5, 1,1,'hA0, 1,'hA0);
        // flush with step high; data held, valid returns after 4 steps
        row(1,1,1,4,1,'hB0, 1,1,'h08, 1,'h08);
        row(1,0,1,4,1,'hB1, 1,0,'h08, 1,'h08);
        row(1,0,1,4,1,'hB2, 1,0,'hA0, 1,'hA0);
        row(1,0,1,4,1,'hB3, 1,0,'hA1, 1,'hA1);
        row(1,0,1,4,1,'hB4, 1,0,'hA4, 1,'hA4);
        row(1,0,1,4,1,'hB5, 1,1,'hB1, 1,'hB1);
        // dly 2->6 after flush
        row(1,0,0,6,1,'hB5, 1,0,'hA4, 1,'hA4);
        row(1,0,0,2,1,'hB5, 1,1,'hB4, 1,'hB4);
        row(1,0,1,6,1,'hB6, 1,0,'hA4, 1,'hA4);
        row(1,0,1,6,1,'hB7, 1,1,'hB1, 1,'hB1);
        row(1,0,0,8,1,'hB7, 1,0,'hA4, 1,'hA4);
        // invalid sample capture
        row(1,0,1,1,0,'hC0, 1,1,'hB7, 1,'hB7);
        row(1,0,0,1,1,'hC1, 1,0,'hC0, 1,'hC0);
        // reset mid-stream with flush and step high
        row(0,1,1,2,1,'hD0, 1,1,'hB7, 1,'hB7);
        row(1,0,0,2,1,'hD1, 1,0,'h00, 1,'hB7);
        row(1,0,0,8,1,'hD1, 1,0,'h00, 1,'hB1);
        row(1,0,1,2,1,'hE0, 1,0,'h00, 1,'hB7);
        row(1,0,1,2,1,'hE1, 1,0,'h00, 1,'hC0);
        row(1,0,0,2,1,'hE2, 1,1,'hE0, 1,'hE0);

        clr_n = 1'b0; flush = 1'b0; step = 1'b0; dly = '0; in_valid = 1'b0; in = '0;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            clr_n = v.c; flush = v.f; step = v.s; dly = v.d; in_valid = v.iv; in = v.din;
            @(negedge clk);
            if (v.chk) begin
                chk_v("vec_v0", i, ov0, v.ev);
                chk_d("vec_d0", i, o0, v.eo);
                chk_v("vec_v2", i, ov2, v.ev);
                if (v.c2) chk_d("vec_d2", i, o2, v.e2o);
            end
            if (i > 0) begin
                pv = tbl[i-1];
                if (!pv.c) begin
                    chk_v("vec_v1", i, ov1, 1'b0);
                    chk_d("vec_d1", i, o1, 8'h00);
                end else if (pv.chk) begin
                    chk_v("vec_v1", i, ov1, pv.ev & ~pv.f);
                    if (!pv.f) chk_d("vec_d1", i, o1, pv.eo);
                end
            end
            @(posedge clk); #1;
        end

        // random streaming against a queue scoreboard, dly=5
        clr_n = 1'b1; flush = 1'b1; step = 1'b1; dly = 4'd5; in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        q = {};
        for (int k = 0; k < NMAX; k++) q.push_back(9'h000);
        while (q.size() > 5) void'(q.pop_front());
        p0 = 9'h000;
        for (int c = 0; c < 60; c++) begin
            step     = ($urandom_range(0, 3) != 0);
            in_valid = ($urandom_range(0, 4) != 0);
            in       = 8'($urandom);
            @(negedge clk);
            e0 = q[0];
            chk_v("sb_v0", c, ov0, e0.v);
            if (e0.v) chk_d("sb_d0", c, o0, e0.d);
            chk_v("sb_v1", c, ov1, p0.v);
            if (p0.v) chk_d("sb_d1", c, o1, p0.d);
            p0 = e0;
            if (step) begin
                q.push_back({in_valid, in});
                while (q.size() > 5) void'(q.pop_front());
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
